// File: rtl/hps_mailbox_pkg.sv
// Shared constants for the HPS-to-fabric mailbox.
// Register map addresses and register bit positions.
package hps_mailbox_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_CONTROL = 2'd2,
    ADDR_IRQMASK = 2'd3
  } mbx_addr_e;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_LVL_LSB = 8;

  localparam int CTL_EN    = 0;
  localparam int CTL_FLUSH = 1;

  localparam int IM_EMPTY = 0;
  localparam int IM_OVF   = 1;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous FIFO with push/pop/flush and level tracking.
// Head is read from registered storage (no fall-through).
module mailbox_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Next-state for storage, pointers and level; flush beats push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/hps_to_fpga_mailbox.sv
// Avalon-MM mailbox: HPS writes words, fabric drains a valid/ready stream.
// Optional irq port and IRQMASK register with HPS_TO_FPGA_MAILBOX_IRQ_EN.
module hps_to_fpga_mailbox
  import hps_mailbox_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              wr, wr_data, wr_stat, wr_ctl;
  logic              push, pop, drop, flush;
  logic              full, empty;
  logic [LVL_W-1:0]  level;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              enable_q, enable_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
  logic              wr_mask;
  logic [1:0]        mask_q, mask_d;
  logic              irq_q, irq_d;
`endif

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr & (address == ADDR_DATA);
  assign wr_stat = wr & (address == ADDR_STATUS);
  assign wr_ctl  = wr & (address == ADDR_CONTROL);
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
  assign wr_mask = wr & (address == ADDR_IRQMASK);
`endif

  assign out_valid = ~empty & enable_q;
  assign pop       = out_valid & out_ready;
  assign push      = wr_data & (~full | pop);
  assign drop      = wr_data & full & ~pop;
  assign flush     = wr_ctl & writedata[CTL_FLUSH];

  mailbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (writedata),
    .pop       (pop),
    .flush     (flush),
    .head      (out_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Control/status next state and the registered read mux.
  always_comb begin
    shadow_d   = shadow_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;
    rdata_d    = '0;
    if (push)    shadow_d = writedata;
    if (wr_ctl)  enable_d = writedata[CTL_EN];
    if (drop)    overflow_d = 1'b1;
    else if (wr_stat && writedata[ST_OVF]) overflow_d = 1'b0;
    unique case (mbx_addr_e'(address))
      ADDR_DATA: rdata_d = shadow_q;
      ADDR_STATUS: begin
        rdata_d[ST_FULL]  = full;
        rdata_d[ST_EMPTY] = empty;
        rdata_d[ST_OVF]   = overflow_q;
        rdata_d[ST_LVL_LSB +: LVL_W] = level;
      end
      ADDR_CONTROL: rdata_d[CTL_EN] = enable_q;
      ADDR_IRQMASK: begin
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
        rdata_d[1:0] = mask_q;
`endif
      end
      default: rdata_d = '0;
    endcase
  end

  // Control/status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      shadow_q   <= shadow_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  assign readdata = rdata_q;

`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
  // Interrupt mask update and registered interrupt condition.
  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = writedata[1:0];
    irq_d = (mask_q[IM_EMPTY] & empty & enable_q)
          | (mask_q[IM_OVF] & overflow_q);
  end

  // Interrupt registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_hps_to_fpga_mailbox.sv
// Scoreboard bench for hps_to_fpga_mailbox (DEPTH=4, DATA_W=32).
// Drivers queue expectations; one negedge monitor compares.
module tb_hps_to_fpga_mailbox;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
  logic        irq;
`endif

  hps_to_fpga_mailbox #(.DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } probe_t;

  logic [31:0] exp_q[$];
  logic [31:0] exp_rd[$];
  probe_t      probe_q[$];
  logic        rd_req = 1'b0;
  logic        rd_req_d;
  logic        done = 1'b0;
  logic        final_done = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_req_d <= 1'b0;
    else          rd_req_d <= rd_req;
  end

  // Monitor: stream pops, read responses, direct probes, final drain.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected got=%h want=none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL stream got=%h want=%h", out_data, e);
        end
      end
    end
    if (rd_req_d) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected got=%h want=none", readdata);
      end else begin
        logic [31:0] e;
        e = exp_rd.pop_front();
        if (readdata !== e) begin
          errors++;
          $display("FAIL read addr=%0d got=%h want=%h", address, readdata, e);
        end
      end
    end
    while (probe_q.size() != 0) begin
      probe_t p;
      logic [31:0] act;
      p = probe_q.pop_front();
      act = '0;
      case (p.kind)
        0: act = {31'd0, out_valid};
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
        1: act = {31'd0, irq};
`endif
        default: act = readdata;
      endcase
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL %s got=%h want=%h", p.name, act, p.exp);
      end
    end
    if (done && !final_done) begin
      final_done <= 1'b1;
      checks++;
      if (exp_q.size() != 0 || exp_rd.size() != 0) begin
        errors++;
        $display("FAIL leftover got=%0d/%0d want=0/0", exp_q.size(), exp_rd.size());
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic push_w(input logic [31:0] d, input bit emerges);
    if (emerges) exp_q.push_back(d);
    wr(2'd0, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    address = a; rd_req = 1'b1; exp_rd.push_back(e);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string n);
    probe_t p;
    p.kind = k; p.exp = e; p.name = n;
    probe_q.push_back(p);
    @(negedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      probe(2, 32'hFFFF_FFFF, "drain_timeout");
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_reset_values();
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h2);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    probe(2, 32'h0, "reset_readdata");
    probe(0, 32'h0, "reset_out_valid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    read_reset_values();

    // Fill with fabric stalled, then drain.
    wr(2'd2, 32'h1);
    push_w(32'hA5A5_0001, 1);
    push_w(32'hA5A5_0002, 1);
    push_w(32'hA5A5_0003, 1);
    push_w(32'hA5A5_0004, 1);
    rd(2'd1, 32'h401);
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    rd(2'd1, 32'h002);

    // Overflow on a full FIFO, then clear it.
    push_w(32'h11, 1);
    push_w(32'h12, 1);
    push_w(32'h13, 1);
    push_w(32'h14, 1);
    push_w(32'hDEAD, 0);
    rd(2'd1, 32'h405);
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h401);

    // Push while full with a same-cycle pop.
    out_ready = 1'b1;
    push_w(32'hBEEF, 1);
    out_ready = 1'b0;
    rd(2'd1, 32'h401);
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    rd(2'd1, 32'h002);
    rd(2'd0, 32'hBEEF);

    // Disabled output, then flush.
    wr(2'd2, 32'h0);
    push_w(32'h21, 0);
    push_w(32'h22, 0);
    out_ready = 1'b1;
    probe(0, 32'h0, "disabled_out_valid");
    idle(2);
    rd(2'd1, 32'h200);
    wr(2'd2, 32'h2);
    rd(2'd1, 32'h002);
    rd(2'd0, 32'h22);
    rd(2'd2, 32'h0);
    wr(2'd2, 32'h1);
    probe(0, 32'h0, "empty_out_valid");
    out_ready = 1'b0;

`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
    wr(2'd3, 32'h1);
    @(posedge clk); #1;
    probe(1, 32'h1, "irq_empty");
    rd(2'd3, 32'h1);
`endif
    push_w(32'h31, 0);
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
    @(posedge clk); #1;
    probe(1, 32'h0, "irq_after_push");
`endif

    // Reset mid-burst with a full FIFO and overflow set.
    push_w(32'h32, 0);
    push_w(32'h33, 0);
    push_w(32'h34, 0);
    push_w(32'h35, 0);
    rd(2'd1, 32'h405);
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
    wr(2'd3, 32'h3);
    idle(2);
    probe(1, 32'h1, "irq_overflow");
`endif
    @(posedge clk); #2;
    reset_n = 1'b0;
    probe(2, 32'h0, "midreset_readdata");
    probe(0, 32'h0, "midreset_out_valid");
`ifdef HPS_TO_FPGA_MAILBOX_IRQ_EN
    probe(1, 32'h0, "midreset_irq");
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    read_reset_values();
    out_ready = 1'b1;
    idle(3);
    out_ready = 1'b0;

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
